// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the two-requester data-memory arbiter: requester IDs,
// FSM state encodings and the saturating burst-count helper.
package dmem_arbiter_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    // Counts up to the limit and then holds there.
    function automatic logic [BURST_W-1:0] burst_inc(
        input logic [BURST_W-1:0] cnt,
        input logic [BURST_W-1:0] lim
    );
        return (cnt < lim) ? cnt + 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: a lone requester wins; on a tie the requester
// that was not granted most recently wins.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_pick
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_pick  = REQ_CPU;
        if (i_req0 && i_req1) begin
            o_pick = (i_last == REQ_DBG) ? REQ_CPU : REQ_DBG;
        end else if (i_req1) begin
            o_pick = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a loader/debug port onto one single-cycle data
// memory port, with round-robin fairness and bounded lock bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [BURST_W-1:0]   r_burst;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic                 r_last;
    logic                 r_pend0;
    logic                 r_pend1;

    logic                 w_rr_valid;
    logic                 w_rr_pick;
    logic                 w_rr_gnt0;
    logic                 w_rr_gnt1;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_rotate;
    logic                 w_burst_full;

    rr_pick2 u_rr (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (r_last),
        .o_valid (w_rr_valid),
        .o_pick  (w_rr_pick)
    );

    assign w_rr_gnt0    = w_rr_valid && (w_rr_pick == REQ_CPU);
    assign w_rr_gnt1    = w_rr_valid && (w_rr_pick == REQ_DBG);
    assign w_burst_full = (r_burst >= BURST_LIM);

    // Grant decision; a lock holder keeps the port until its burst is spent
    // and the other side is waiting, at which point the grant is handed over.
    always_comb begin
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_rotate = 1'b0;
        if (!reset) begin
            unique case (r_state)
                ST_LOCK0: begin
                    if (req0) begin
                        if (w_burst_full && req1) begin
                            w_gnt1   = 1'b1;
                            w_rotate = 1'b1;
                        end else begin
                            w_gnt0 = 1'b1;
                        end
                    end else begin
                        w_gnt0 = w_rr_gnt0;
                        w_gnt1 = w_rr_gnt1;
                    end
                end
                ST_LOCK1: begin
                    if (req1) begin
                        if (w_burst_full && req0) begin
                            w_gnt0   = 1'b1;
                            w_rotate = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
                    end else begin
                        w_gnt0 = w_rr_gnt0;
                        w_gnt1 = w_rr_gnt1;
                    end
                end
                default: begin
                    w_gnt0 = w_rr_gnt0;
                    w_gnt1 = w_rr_gnt1;
                end
            endcase
        end
    end

    // Next state: the grant that takes a lock counts as the first of the burst.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
        if (!w_rotate) begin
            if (w_gnt0 && lock0) begin
                w_state_nxt = ST_LOCK0;
                w_burst_nxt = (r_state == ST_LOCK0) ? burst_inc(r_burst, BURST_LIM)
                                                    : BURST_W'(1);
            end else if (w_gnt1 && lock1) begin
                w_state_nxt = ST_LOCK1;
                w_burst_nxt = (r_state == ST_LOCK1) ? burst_inc(r_burst, BURST_LIM)
                                                    : BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
            r_last  <= REQ_DBG;
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            if (w_gnt0) begin
                r_last <= REQ_CPU;
            end else if (w_gnt1) begin
                r_last <= REQ_DBG;
            end
            r_pend0 <= w_gnt0 & ~we0;
            r_pend1 <= w_gnt1 & ~we1;
        end
    end

    always_comb begin
        mem_en    = w_gnt0 | w_gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_pend0;
    assign rvalid1 = r_pend1;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, word-address width of the shared data memory port (64 words).
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive locked grants to one requester while the other waits; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clock, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Ports req0/req1, input, 1 each, access request from requester 0 (CPU load/store) and requester 1 (loader/debug).
REQ-008 Ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-009 Ports lock0/lock1, input, 1 each, request to keep the grant on the next cycle.
REQ-010 Ports addr0/addr1, input, ADDR_WIDTH each, word address.
REQ-011 Ports wdata0/wdata1, input, DATA_WIDTH each, write data.
REQ-012 Ports gnt0/gnt1, output, 1 each, access accepted this cycle.
REQ-013 Ports rvalid0/rvalid1, output, 1 each, read data valid for that requester.
REQ-014 Ports rdata0/rdata1, output, DATA_WIDTH each, read data; both equal mem_rdata.
REQ-015 Ports mem_en, mem_we, output, 1 each; mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH: memory command.
REQ-016 Port mem_rdata, input, DATA_WIDTH, memory read data, valid one cycle after a read command.

Function
REQ-017 Grant SHALL be combinational in the request cycle; at most one of gnt0/gnt1 high; gnt only when the matching req is high.
REQ-018 When granted, mem_en=1, mem_we/mem_addr/mem_wdata SHALL equal the granted requester's inputs that cycle; with no grant, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-019 A registered pointer last_gnt SHALL select priority: the requester not granted most recently wins when both request.
REQ-020 States: IDLE (no lock held), LOCK0, LOCK1.
REQ-021 In LOCKn, requester n SHALL win regardless of pointer if reqn=1.
REQ-022 Transition to LOCKn when gntn=1 and lockn=1; return to IDLE when reqn=0, lockn=0, or the burst limit forces rotation.
REQ-023 A 4-bit burst counter SHALL count consecutive grants in LOCKn; when it reaches MAX_BURST and the other requester is requesting, the grant SHALL go to the other requester that cycle and the state SHALL return to IDLE.
REQ-024 When the other requester is idle, a lock SHALL persist beyond MAX_BURST; the counter saturates.
REQ-025 A granted read SHALL assert rvalidn exactly one cycle later for one cycle; a granted write SHALL produce no rvalid.
REQ-026 Back-to-back reads from alternating requesters SHALL each return their own rvalid in order, one per cycle; full throughput is one access per cycle.
REQ-027 Simultaneous req0 and req1 in IDLE with last_gnt=1 SHALL grant requester 0.

Reset
REQ-028 While reset is high: gnt0=gnt1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid0=rvalid1=0, state=IDLE, burst counter=0, last_gnt=1 (requester 0 has priority first).
REQ-029 Reset asserted mid-read SHALL suppress the pending rvalid; no rvalid after reset release without a new grant.

Structure
REQ-030 State encodings and requester ID constants (REQ_CPU=0, REQ_DBG=1) SHALL live in the shared constants header.
REQ-031 One sub-module, rr_pick2, SHALL hold the two-way round-robin choice; the FSM, counter and rvalid tracking stay in dmem_arbiter.

Verification
REQ-032 Only req0=1, we0=0, addr0=5, memory[5]=0x0000_0005 -> gnt0=1 same cycle, rvalid0=1 and rdata0=0x5 next cycle.
REQ-033 req0=req1=1 held with writes for 4 cycles after reset -> grants 0,1,0,1; mem_we=1 each cycle.
REQ-034 req1=lock1=1 and req0=1 held, MAX_BURST=4 -> gnt1 for 4 cycles, then gnt0 on cycle 5.
REQ-035 Read by requester 0 at addr 3 then requester 1 at addr 7 on consecutive cycles -> rvalid0 with mem[3], then rvalid1 with mem[7], no overlap.
REQ-036 Reset pulsed on the cycle after a granted read -> rvalid0 stays 0; after release the first grant goes to requester 0.
REQ-037 lock0=1 with req1=0 for 10 cycles -> gnt0 every cycle, state stays LOCK0, counter saturated at MAX_BURST.
